// File: rtl/grid_cmd_sched.sv
// Two-requester round-robin command scheduler feeding the 3x3 grid mover; one registered command per clock.
// Latency: a push reaches cmd_out one edge later at the earliest; ready is driven from the registered FIFO count.

module grid_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // The caller only pushes when not full and only pops when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head = mem[rd_ptr];
endmodule

module grid_cmd_sched #(
    parameter int         DEPTH    = 4,
    parameter logic [3:0] IDLE_CMD = 4'b1111
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] req0_cmd,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req1_cmd,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] cmd_out,
    output logic       mode_out,
    output logic       issue_valid,
    output logic       grant,
    output logic [1:0] reject,
    output logic [7:0] issued_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_CLEAR} state_t;

    state_t        state;
    logic          last_grant;
    logic [3:0]    head0, head1;
    logic [CW-1:0] count0, count1;
    logic          legal0, legal1;
    logic          acc0, acc1;
    logic          push0, push1;
    logic          pop0, pop1;
    logic          ne0, ne1;
    logic          can_issue;
    logic          pick1;
    logic          any_ne;

    assign req0_ready = (count0 < CW'(DEPTH));
    assign req1_ready = (count1 < CW'(DEPTH));

    assign legal0 = (req0_cmd <= 4'd8);
    assign legal1 = (req1_cmd <= 4'd8);
    assign acc0   = req0_valid && req0_ready;
    assign acc1   = req1_valid && req1_ready;
    // Illegal codes are consumed without being stored; anything pushed during clear is dropped.
    assign push0  = acc0 && legal0 && !clear;
    assign push1  = acc1 && legal1 && !clear;

    assign ne0       = (count0 != '0);
    assign ne1       = (count1 != '0);
    assign any_ne    = ne0 || ne1;
    assign can_issue = !clear && !pause && (state != ST_CLEAR);
    // Requester 1 wins when it alone has work, or both do and requester 0 went last.
    assign pick1     = ne1 && (!ne0 || !last_grant);
    assign pop0      = can_issue && ne0 && !pick1;
    assign pop1      = can_issue && pick1;

    grid_cmd_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo0 (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .flush    (clear),
        .push     (push0),
        .push_dat (req0_cmd),
        .pop      (pop0),
        .head     (head0),
        .count    (count0)
    );

    grid_cmd_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo1 (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .flush    (clear),
        .push     (push1),
        .push_dat (req1_cmd),
        .pop      (pop1),
        .head     (head1),
        .count    (count1)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_RUN;
            cmd_out     <= IDLE_CMD;
            mode_out    <= 1'b0;
            issue_valid <= 1'b0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            reject      <= 2'b00;
            issued_cnt  <= 8'd0;
        end else begin
            reject <= {acc1 && !legal1 && !clear, acc0 && !legal0 && !clear};
            if (clear) begin
                state       <= ST_CLEAR;
                mode_out    <= 1'b1;
                cmd_out     <= IDLE_CMD;
                issue_valid <= 1'b0;
                issued_cnt  <= 8'd0;
                last_grant  <= 1'b1;
            end else begin
                mode_out <= 1'b0;
                state    <= pause ? ST_HOLD : ST_RUN;
                if (can_issue && any_ne) begin
                    cmd_out     <= pick1 ? head1 : head0;
                    issue_valid <= 1'b1;
                    grant       <= pick1;
                    last_grant  <= pick1;
                    issued_cnt  <= issued_cnt + 8'd1;
                end else begin
                    cmd_out     <= IDLE_CMD;
                    issue_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_grid_cmd_sched.sv
// Bench for grid_cmd_sched: directed scenarios plus random traffic, all checked against a queue-based model.
module tb_grid_cmd_sched;
    localparam int         D    = 4;
    localparam logic [3:0] IDLE = 4'b1111;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] req0_cmd = 4'd0, req1_cmd = 4'd0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic       pause = 1'b0, clear = 1'b0;
    logic [3:0] cmd_out;
    logic       mode_out, issue_valid, grant;
    logic [1:0] reject;
    logic [7:0] issued_cnt;

    grid_cmd_sched #(.DEPTH(D), .IDLE_CMD(IDLE)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .req0_cmd    (req0_cmd),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req1_cmd    (req1_cmd),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .pause       (pause),
        .clear       (clear),
        .cmd_out     (cmd_out),
        .mode_out    (mode_out),
        .issue_valid (issue_valid),
        .grant       (grant),
        .reject      (reject),
        .issued_cnt  (issued_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic       m_last;
    logic [3:0] e_cmd;
    logic       e_mode, e_iv, e_grant;
    logic [1:0] e_rej;
    logic [7:0] e_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_last  = 1'b1;
        e_cmd   = IDLE;
        e_mode  = 1'b0;
        e_iv    = 1'b0;
        e_grant = 1'b0;
        e_rej   = 2'b00;
        e_cnt   = 8'd0;
    endtask

    // Applies the rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit a0, a1;
        int pick;
        a0 = req0_valid && (q0.size() < D);
        a1 = req1_valid && (q1.size() < D);
        e_rej = {a1 && (req1_cmd > 4'd8) && !clear, a0 && (req0_cmd > 4'd8) && !clear};
        if (clear) begin
            q0.delete();
            q1.delete();
            e_mode = 1'b1;
            e_cmd  = IDLE;
            e_iv   = 1'b0;
            e_cnt  = 8'd0;
            m_last = 1'b1;
        end else begin
            e_mode = 1'b0;
            pick = -1;
            if (!pause) begin
                if (q0.size() > 0 && q1.size() > 0) pick = m_last ? 0 : 1;
                else if (q0.size() > 0)             pick = 0;
                else if (q1.size() > 0)             pick = 1;
            end
            if (pick == 0) begin
                e_cmd = q0.pop_front();
            end else if (pick == 1) begin
                e_cmd = q1.pop_front();
            end
            if (pick >= 0) begin
                e_iv    = 1'b1;
                e_grant = (pick == 1);
                m_last  = (pick == 1);
                e_cnt   = e_cnt + 8'd1;
            end else begin
                e_cmd = IDLE;
                e_iv  = 1'b0;
            end
            if (a0 && req0_cmd <= 4'd8) q0.push_back(req0_cmd);
            if (a1 && req1_cmd <= 4'd8) q1.push_back(req1_cmd);
        end
    endtask

    task automatic compare_all();
        chk("cmd_out", cmd_out, e_cmd);
        chk("mode_out", mode_out, e_mode);
        chk("issue_valid", issue_valid, e_iv);
        if (e_iv) chk("grant", grant, e_grant);
        chk("reject", reject, e_rej);
        chk("issued_cnt", issued_cnt, e_cnt);
        chk("req0_ready", req0_ready, q0.size() < D);
        chk("req1_ready", req1_ready, q1.size() < D);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd"}, cmd_out, IDLE);
        chk({tag, "_mode"}, mode_out, 1'b0);
        chk({tag, "_iv"}, issue_valid, 1'b0);
        chk({tag, "_grant"}, grant, 1'b0);
        chk({tag, "_rej"}, reject, 2'b00);
        chk({tag, "_cnt"}, issued_cnt, 8'd0);
        chk({tag, "_rdy0"}, req0_ready, 1'b1);
        chk({tag, "_rdy1"}, req1_ready, 1'b1);
    endtask

    initial begin
        model_reset();
        // Reset and idle
        repeat (2) @(negedge CLK);
        check_reset_vals("rst");
        RESET_N = 1'b1;
        repeat (5) begin
            step();
            chk("idle_cmd", cmd_out, IDLE);
        end

        // Single-requester order
        req0_valid = 1'b1; req0_cmd = 4'b0010; step();
        req0_cmd = 4'b0100; step();
        chk("ord_1", cmd_out, 4'b0010); chk("ord_g1", grant, 1'b0);
        req0_cmd = 4'b0001; step();
        chk("ord_2", cmd_out, 4'b0100);
        req0_valid = 1'b0; step();
        chk("ord_3", cmd_out, 4'b0001);
        step();
        chk("ord_idle", cmd_out, IDLE);
        chk("ord_cnt", issued_cnt, 8'd3);

        // Clear restores requester 0 priority, then round-robin preload
        clear = 1'b1; step();
        chk("clr0_mode", mode_out, 1'b1);
        clear = 1'b0; step();
        chk("clr0_mode_off", mode_out, 1'b0);
        pause = 1'b1;
        req0_valid = 1'b1; req0_cmd = 4'b0010;
        req1_valid = 1'b1; req1_cmd = 4'b0110;
        step(); step();
        req0_valid = 1'b0; req1_valid = 1'b0; pause = 1'b0;
        step(); chk("rr_c0", cmd_out, 4'b0010); chk("rr_g0", grant, 1'b0);
        step(); chk("rr_c1", cmd_out, 4'b0110); chk("rr_g1", grant, 1'b1);
        step(); chk("rr_c2", cmd_out, 4'b0010); chk("rr_g2", grant, 1'b0);
        step(); chk("rr_c3", cmd_out, 4'b0110); chk("rr_g3", grant, 1'b1);

        // Full FIFO
        pause = 1'b1; req1_valid = 1'b1;
        req1_cmd = 4'd1; step();
        req1_cmd = 4'd2; step();
        req1_cmd = 4'd3; step();
        req1_cmd = 4'd5; step();
        chk("full_rdy", req1_ready, 1'b0);
        req1_cmd = 4'd7; step();
        req1_valid = 1'b0; pause = 1'b0;
        step(); chk("full_1", cmd_out, 4'd1);
        step(); chk("full_2", cmd_out, 4'd2);
        step(); chk("full_3", cmd_out, 4'd3);
        step(); chk("full_5", cmd_out, 4'd5);
        step(); chk("full_idle", issue_valid, 1'b0);

        // Reject
        req0_valid = 1'b1; req0_cmd = 4'b1010; step();
        chk("rej_pulse", reject, 2'b01);
        req0_valid = 1'b0; step();
        chk("rej_off", reject, 2'b00);
        chk("rej_noissue", issue_valid, 1'b0);

        // Clear sequencing with three entries queued
        pause = 1'b1;
        req0_valid = 1'b1; req0_cmd = 4'd1; req1_valid = 1'b1; req1_cmd = 4'd3; step();
        req1_valid = 1'b0; req0_cmd = 4'd2; step();
        req0_valid = 1'b0; pause = 1'b0; clear = 1'b1; step();
        chk("clr_mode", mode_out, 1'b1); chk("clr_cnt", issued_cnt, 8'd0);
        clear = 1'b0; step();
        chk("clr_mode_off", mode_out, 1'b0); chk("clr_iv", issue_valid, 1'b0);
        req0_valid = 1'b1; req0_cmd = 4'd5; req1_valid = 1'b1; req1_cmd = 4'd6; step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); chk("clr_first", cmd_out, 4'd5); chk("clr_first_g", grant, 1'b0);
        step(); chk("clr_second", cmd_out, 4'd6); chk("clr_second_g", grant, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_cmd   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            req1_cmd   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            pause      = ($urandom_range(0, 99) < 10);
            clear      = ($urandom_range(0, 99) < 3);
            step();
        end

        // Asynchronous reset between edges while traffic is flowing
        pause = 1'b0; clear = 1'b0;
        req0_valid = 1'b1; req0_cmd = 4'd3; req1_valid = 1'b1; req1_cmd = 4'd4;
        step(); step(); step();
        chk("pre_arst_iv", issue_valid, 1'b1);
        #2 RESET_N = 1'b0;
        #1 check_reset_vals("arst");
        model_reset();
        @(negedge CLK);
        req0_valid = 1'b0; req1_valid = 1'b0;
        RESET_N = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
